// File: rtl/add_sub_logic.sv
// add_sub_logic: 16-bit ALU slice (add / sub / invert-b / unsigned compare).
// The result r is purely combinational. r_q and the status flags are
// registered copies for the next pipeline stage.
module add_sub_logic #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_q,
  output logic             carry_q,
  output logic             ovf_q,
  output logic             zero_q
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_INV = 2'd2;
  localparam logic [1:0] OP_CMP = 2'd3;

  // One extra bit on each datapath carries the carry-out or borrow.
  logic [WIDTH:0] sum, dif, cmp;
  logic           carry, ovf, zero;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  // The borrow of b - a is set exactly when b < a (unsigned).
  assign cmp = {1'b0, b} - {1'b0, a};

  // Result and flag select. Every path assigns a default, so no latch is inferred.
  always_comb begin
    r     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        r     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r     = dif[WIDTH-1:0];
        carry = dif[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INV: begin
        r = ~b;
      end
      OP_CMP: begin
        r     = {{(WIDTH-1){1'b0}}, cmp[WIDTH]};
        carry = cmp[WIDTH];
      end
      default: begin
        r = '0;
      end
    endcase
  end

  assign zero = (r == '0);

  // Capture result and flags. Reset wins and leaves zero_q set to match r_q = 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      r_q     <= r;
      carry_q <= carry;
      ovf_q   <= ovf;
      zero_q  <= zero;
    end
  end

endmodule

// File: tb/tb_add_sub_logic.sv
// Scoreboard bench for add_sub_logic. Stimulus pushes expected items into a
// queue. The monitor pops one item per cycle and checks r. One cycle later it
// checks the registered outputs against the same item.
module tb_add_sub_logic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic [15:0] r, r_q;
  logic        carry_q, ovf_q, zero_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  op;
    logic [15:0] a, b, r;
    logic        c, v, z;
  } item_t;

  item_t q[$];

  add_sub_logic #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .op(op), .a(a), .b(b),
    .r(r), .r_q(r_q), .carry_q(carry_q), .ovf_q(ovf_q), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model, built from integer arithmetic and signed range checks.
  function automatic item_t model(input logic rst, input logic [1:0] o,
                                  input logic [15:0] x, input logic [15:0] y);
    item_t it;
    int ux, uy, sx, sy, s;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    it.rst = rst; it.op = o; it.a = x; it.b = y;
    it.c = 1'b0; it.v = 1'b0;
    case (o)
      2'd0: begin
        s = ux + uy; it.r = 16'(s); it.c = (s > 65535);
        s = sx + sy; it.v = (s > 32767) || (s < -32768);
      end
      2'd1: begin
        s = ux - uy; it.r = 16'(s); it.c = (ux < uy);
        s = sx - sy; it.v = (s > 32767) || (s < -32768);
      end
      2'd2: it.r = 16'hFFFF - y;
      default: begin it.r = (uy < ux) ? 16'd1 : 16'd0; it.c = (uy < ux); end
    endcase
    it.z = (it.r == 16'd0);
    return it;
  endfunction

  // Drive one cycle of stimulus and push its hand-computed expectation.
  task automatic issue(input logic rst, input logic [1:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] er,
                       input logic ec, input logic ev, input logic ez);
    item_t it;
    reset = rst; op = o; a = x; b = y;
    it.rst = rst; it.op = o; it.a = x; it.b = y;
    it.r = er; it.c = ec; it.v = ev; it.z = ez;
    q.push_back(it);
    @(posedge clk); #1;
  endtask

  task automatic issue_rand();
    logic [1:0]  o;
    logic [15:0] x, y;
    item_t it;
    o = 2'($urandom_range(0, 3));
    x = 16'($urandom); y = 16'($urandom);
    it = model(1'b0, o, x, y);
    issue(1'b0, o, x, y, it.r, it.c, it.v, it.z);
  endtask

  // Monitor: r is checked against the item issued this cycle. The registered
  // outputs are checked against the item issued in the previous cycle.
  item_t pend;
  bit    pend_vld = 1'b0;
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        it = q.pop_front();
        chk("r", r, it.r);
        if (it.op == 2'd2) chk("r_xor_b", r ^ it.b, 16'hFFFF);
        if (pend_vld) begin
          if (pend.rst) begin
            chk("r_q_rst", r_q, 16'h0);
            chk("carry_q_rst", {15'b0, carry_q}, 16'h0);
            chk("ovf_q_rst", {15'b0, ovf_q}, 16'h0);
            chk("zero_q_rst", {15'b0, zero_q}, 16'h1);
          end else begin
            chk("r_q", r_q, pend.r);
            chk("carry_q", {15'b0, carry_q}, {15'b0, pend.c});
            chk("ovf_q", {15'b0, ovf_q}, {15'b0, pend.v});
            chk("zero_q", {15'b0, zero_q}, {15'b0, pend.z});
          end
        end
        pend = it;
        pend_vld = 1'b1;
      end
    end
  end

  initial begin
    reset = 1'b1; op = 2'd0; a = 16'h0; b = 16'h0;
    @(posedge clk); #1;
    // reset held for two edges
    issue(1, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    issue(1, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    // add
    issue(0, 2'd0, 16'd2,    16'd3,    16'd5,    0, 0, 0);
    issue(0, 2'd0, 16'd100,  16'd200,  16'h012C, 0, 0, 0);
    issue(0, 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1);
    issue(0, 2'd0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0);
    // subtract
    issue(0, 2'd1, 16'd10,   16'd5,    16'd5,    0, 0, 0);
    issue(0, 2'd1, 16'd100,  16'd200,  16'hFF9C, 1, 0, 0);
    issue(0, 2'd1, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0);
    issue(0, 2'd1, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0);
    issue(0, 2'd1, 16'd5,    16'd5,    16'h0000, 0, 0, 1);
    // invert
    issue(0, 2'd2, 16'd7,    16'd11,   16'hFFF4, 0, 0, 0);
    issue(0, 2'd2, 16'd11,   16'd7,    16'hFFF8, 0, 0, 0);
    issue(0, 2'd2, 16'h1234, 16'hFFFF, 16'h0000, 0, 0, 1);
    // compare
    issue(0, 2'd3, 16'd3,    16'd10,   16'h0000, 0, 0, 1);
    issue(0, 2'd3, 16'd10,   16'd3,    16'h0001, 1, 0, 0);
    issue(0, 2'd3, 16'd5,    16'd5,    16'h0000, 0, 0, 1);
    // mid-stream reset: r keeps tracking while r_q clears
    issue(0, 2'd0, 16'd2,    16'd3,    16'd5,    0, 0, 0);
    issue(1, 2'd0, 16'd2,    16'd3,    16'd5,    0, 0, 0);
    issue(0, 2'd0, 16'd2,    16'd3,    16'd5,    0, 0, 0);
    issue(0, 2'd1, 16'd7,    16'd9,    16'hFFFE, 1, 0, 0);
    // random sweep
    for (int i = 0; i < 1000; i++) issue_rand();
    // trailing item so the last random result gets its registered check
    issue(0, 2'd2, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d items left expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
